first_press_arbiter: RTL and testbench



---
 rtl/first_press_arbiter.sv | 135 +++++++++++++
 tb/tb_first_press_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/first_press_arbiter.sv
// Buzz-in arbiter: decodes keypad codes into player presses, latches the first
// eligible press of an armed round, records false starts and flags timeouts.
module first_press_arbiter #(
    parameter int                          N_PLAYERS   = 4,
    parameter int                          KEY_W       = 4,
    parameter logic [N_PLAYERS*KEY_W-1:0]  KEY_CODES   = {4'h3, 4'h1, 4'h7, 4'h9},
    parameter int                          TIMEOUT_CYC = 1000,
    parameter int                          ID_W        = $clog2(N_PLAYERS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KEY_W-1:0]     keypad_in,
    input  logic                 keypad_valid,
    input  logic                 arm,
    output logic                 armed,
    output logic                 winner_valid,
    output logic [ID_W-1:0]      winner_id,
    output logic [N_PLAYERS-1:0] winner_onehot,
    output logic [N_PLAYERS-1:0] disq,
    output logic                 timeout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // A zero timeout still needs a legal one-bit counter.
    localparam int CNT_W    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int CNT_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LAST_V = CNT_W'(CNT_LAST);
    localparam logic [CNT_W-1:0] CNT_MAX_V  = CNT_W'(TIMEOUT_CYC);

    // Walk downwards so the lowest matching player is the one left standing.
    function automatic logic [N_PLAYERS-1:0] decode_first(input logic             vld,
                                                          input logic [KEY_W-1:0] code);
        logic [N_PLAYERS-1:0] oh;
        oh = '0;
        if (vld) begin
            for (int i = N_PLAYERS - 1; i >= 0; i--) begin
                if (code == KEY_CODES[i*KEY_W +: KEY_W]) begin
                    oh    = '0;
                    oh[i] = 1'b1;
                end
            end
        end
        return oh;
    endfunction

    function automatic logic [ID_W-1:0] onehot_to_id(input logic [N_PLAYERS-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            if (oh[i]) id = id | ID_W'(i);
        end
        return id;
    endfunction

    logic [1:0]           state;
    logic [CNT_W-1:0]     counter;
    logic [N_PLAYERS-1:0] hit_oh;
    logic [ID_W-1:0]      hit_id;
    logic                 valid_hit;
    logic                 last_cyc;

    always_comb begin
        hit_oh    = decode_first(keypad_valid, keypad_in);
        hit_id    = onehot_to_id(hit_oh);
        valid_hit = |(hit_oh & ~disq);
        last_cyc  = (TIMEOUT_CYC != 0) && (counter == CNT_LAST_V);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            armed         <= 1'b0;
            winner_valid  <= 1'b0;
            winner_id     <= '0;
            winner_onehot <= '0;
            disq          <= '0;
            timeout       <= 1'b0;
            counter       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (arm) begin
                        state         <= S_ARMED;
                        armed         <= 1'b1;
                        winner_valid  <= 1'b0;
                        winner_id     <= '0;
                        winner_onehot <= '0;
                        timeout       <= 1'b0;
                        counter       <= '0;
                    end else begin
                        disq <= disq | hit_oh;
                    end
                end
                S_ARMED: begin
                    // An eligible press beats both a re-arm and the final-cycle timeout.
                    if (valid_hit) begin
                        state         <= S_DONE;
                        armed         <= 1'b0;
                        winner_valid  <= 1'b1;
                        winner_id     <= hit_id;
                        winner_onehot <= hit_oh;
                    end else if (arm) begin
                        counter <= '0;
                    end else if (last_cyc) begin
                        state   <= S_DONE;
                        armed   <= 1'b0;
                        timeout <= 1'b1;
                    end else if (counter != CNT_MAX_V) begin
                        counter <= counter + 1'b1;
                    end
                end
                S_DONE: begin
                    if (arm) begin
                        state         <= S_ARMED;
                        armed         <= 1'b1;
                        winner_valid  <= 1'b0;
                        winner_id     <= '0;
                        winner_onehot <= '0;
                        disq          <= '0;
                        timeout       <= 1'b0;
                        counter       <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    armed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_first_press_arbiter.sv
// Bench for first_press_arbiter: directed round scenarios plus random traffic,
// compared every cycle against a round-level model of the game.
module tb_first_press_arbiter;

    localparam int N  = 4;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   keypad_in;
    logic         keypad_valid;
    logic         arm;
    logic         armed;
    logic         winner_valid;
    logic [1:0]   winner_id;
    logic [N-1:0] winner_onehot;
    logic [N-1:0] disq;
    logic         timeout;

    first_press_arbiter #(
        .N_PLAYERS  (N),
        .KEY_W      (4),
        .KEY_CODES  ({4'h3, 4'h1, 4'h7, 4'h9}),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .keypad_in    (keypad_in),
        .keypad_valid (keypad_valid),
        .arm          (arm),
        .armed        (armed),
        .winner_valid (winner_valid),
        .winner_id    (winner_id),
        .winner_onehot(winner_onehot),
        .disq         (disq),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    int codes[N] = '{9, 7, 1, 3};
    int total = 0;
    int fails = 0;

    // Round-level model: is a round open, has it been decided, and how long it has run.
    bit       m_open, m_done, m_wv, m_to;
    bit [3:0] m_disq;
    int       m_wid, m_elapsed;
    bit       started = 0;

    always @(posedge clk) begin
        int first;
        first = -1;
        if (keypad_valid)
            for (int i = N - 1; i >= 0; i--)
                if (int'(keypad_in) == codes[i]) first = i;
        if (!rst) begin
            m_open = 0; m_done = 0; m_wv = 0; m_to = 0;
            m_disq = 0; m_wid = 0; m_elapsed = 0;
        end else if (m_open) begin
            if (first >= 0 && !m_disq[first]) begin
                m_open = 0; m_done = 1; m_wv = 1; m_wid = first;
            end else if (arm) begin
                m_elapsed = 0;
            end else begin
                m_elapsed++;
                if (m_elapsed == TO) begin
                    m_open = 0; m_done = 1; m_to = 1;
                end
            end
        end else if (arm) begin
            if (m_done) m_disq = 0;
            m_open = 1; m_done = 0; m_wv = 0; m_wid = 0; m_to = 0; m_elapsed = 0;
        end else if (!m_done && first >= 0) begin
            m_disq[first] = 1;
        end
        started = 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("armed", 32'(armed), 32'(m_open));
            chk("winner_valid", 32'(winner_valid), 32'(m_wv));
            chk("winner_id", 32'(winner_id), m_wv ? 32'(m_wid) : 32'd0);
            chk("winner_onehot", 32'(winner_onehot), m_wv ? (32'd1 << m_wid) : 32'd0);
            chk("disq", 32'(disq), 32'(m_disq));
            chk("timeout", 32'(timeout), 32'(m_to));
        end
    end

    task automatic cyc(input logic a, input logic kv, input logic [3:0] kc);
        arm = a; keypad_valid = kv; keypad_in = kc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 4'h0);
    endtask

    task automatic do_reset();
        rst = 0;
        cyc(0, 0, 4'h0);
        rst = 1;
    endtask

    initial begin
        rst = 0; arm = 0; keypad_valid = 0; keypad_in = 0;
        cyc(0, 0, 4'h0);
        cyc(0, 0, 4'h0);
        chk("rst_armed", 32'(armed), 0);
        chk("rst_wv", 32'(winner_valid), 0);
        chk("rst_disq", 32'(disq), 0);
        chk("rst_to", 32'(timeout), 0);
        rst = 1;

        // Player 0 wins; a later key changes nothing
        cyc(1, 0, 4'h0);
        chk("s1_armed", 32'(armed), 1);
        cyc(0, 1, 4'h9);
        chk("s1_wv", 32'(winner_valid), 1);
        chk("s1_id", 32'(winner_id), 0);
        chk("s1_oh", 32'(winner_onehot), 4'b0001);
        chk("s1_armed_off", 32'(armed), 0);
        chk("pin_m_wid0", 32'(m_wid), 0);
        cyc(0, 1, 4'h7);
        chk("s1_hold_oh", 32'(winner_onehot), 4'b0001);

        // Player 1 wins from a re-arm; invalid X keys are ignored
        cyc(1, 0, 4'h0);
        cyc(0, 0, 4'bxxxx);
        chk("s2_x_armed", 32'(armed), 1);
        cyc(0, 1, 4'h5);
        chk("s2_nomatch", 32'(armed), 1);
        cyc(0, 1, 4'h7);
        cyc(0, 1, 4'h9);
        chk("s2_id", 32'(winner_id), 1);
        chk("s2_oh", 32'(winner_onehot), 4'b0010);
        cyc(0, 0, 4'bxxxx);
        chk("s2_x_hold", 32'(winner_onehot), 4'b0010);

        // False start by player 1 carries into the round
        do_reset();
        cyc(0, 1, 4'h7);
        chk("s3_disq", 32'(disq), 4'b0010);
        chk("pin_m_disq", 32'(m_disq), 4'b0010);
        cyc(1, 0, 4'h0);
        cyc(0, 1, 4'h7);
        chk("s3_ign_armed", 32'(armed), 1);
        chk("s3_ign_wv", 32'(winner_valid), 0);
        cyc(0, 1, 4'h1);
        chk("s3_id", 32'(winner_id), 2);
        chk("s3_disq_kept", 32'(disq), 4'b0010);

        // Timeout exactly TO edges after arm
        cyc(1, 0, 4'h0);
        idle(TO - 1);
        chk("s4_pre_armed", 32'(armed), 1);
        chk("s4_pre_to", 32'(timeout), 0);
        idle(1);
        chk("s4_to", 32'(timeout), 1);
        chk("s4_armed", 32'(armed), 0);
        chk("s4_wv", 32'(winner_valid), 0);
        chk("pin_m_to", 32'(m_to), 1);

        // Press on the final armed cycle beats timeout
        cyc(1, 0, 4'h0);
        idle(TO - 1);
        cyc(0, 1, 4'h9);
        chk("s5_wv", 32'(winner_valid), 1);
        chk("s5_to", 32'(timeout), 0);

        // Mid-game reset, then player 3
        do_reset();
        chk("s6_rst_wv", 32'(winner_valid), 0);
        chk("s6_rst_oh", 32'(winner_onehot), 0);
        cyc(1, 0, 4'h0);
        cyc(0, 1, 4'h3);
        chk("s6_id", 32'(winner_id), 3);
        chk("s6_oh", 32'(winner_onehot), 4'b1000);
        chk("pin_m_wid3", 32'(m_wid), 3);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] kc;
            rst = ($urandom_range(0, 199) != 0);
            kc = ($urandom_range(0, 1) != 0) ? 4'(codes[$urandom_range(0, N - 1)])
                                             : 4'($urandom_range(0, 15));
            cyc($urandom_range(0, 11) == 0, $urandom_range(0, 2) == 0, kc);
        end
        rst = 1;
        idle(2);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
